// File: rtl/imem_loader.sv
// imem_loader
//   Loads 32-bit instruction words into a byte-wide instruction memory before
//   the core runs. Each accepted word is written as four little-endian bytes:
//   bits 7:0 go to the lowest address. The core is held in reset (cpu_hold)
//   while a load is in progress.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle load request, honoured only when idle
//   start_addr      : base byte address (bits 1:0 ignored)
//   word_count      : number of words to load (0..MEM_BYTES/4)
//   in_valid/in_data/in_ready : word stream (valid/ready handshake)
//   we/waddr/wdata  : byte write port into the memory array (registered)
//   busy, cpu_hold  : load in progress / keep core in reset (identical)
//   done            : one-cycle pulse when a load completes (registered)
//   err             : one-cycle pulse when a request would overrun memory

module imem_loader #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-2:0] word_count,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [7:0]    wdata,
    output logic          busy,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_WORD = 2'd1;
    localparam logic [1:0] WRITE     = 2'd2;
    localparam logic [1:0] FINISH    = 2'd3;

    localparam logic [AW-1:0] WORD_LIMIT = MEM_BYTES / 4;
    localparam logic [AW-3:0] PTR_ONE    = 1;
    localparam logic [AW-2:0] CNT_ONE    = 1;

    logic [1:0]    state;
    logic [AW-3:0] word_ptr;
    logic [AW-2:0] remaining;
    logic [31:0]   word;
    logic [1:0]    beat;
    logic [1:0]    beat_next;
    logic [AW-1:0] range_end;
    logic          overflow;

    // Start address is forced word-aligned, so its low bits are not used.
    logic [1:0]    unused_addr_bits;
    assign unused_addr_bits = start_addr[1:0];

    // Sum is formed at AW bits: the largest word index plus the largest
    // count still fits, so the comparison cannot be fooled by a wrap.
    assign range_end = {2'b00, start_addr[AW-1:2]} + {1'b0, word_count};
    assign overflow  = (range_end > WORD_LIMIT);

    assign beat_next = beat + 2'd1;

    assign in_ready = (state == WAIT_WORD);
    assign busy     = (state == WAIT_WORD) || (state == WRITE);
    assign cpu_hold = busy;

    // The byte-write registers are loaded one cycle ahead of the beat they
    // present: beat 0 is loaded on the accepting edge, so WRITE spans exactly
    // the four cycles in which we=1 and beat names the byte being driven.
    // done is raised on the edge leaving WRITE for a last word (so it shows
    // together with FINISH), whereas a zero-count load raises it from inside
    // FINISH; done <= !done in FINISH gives exactly one pulse in both paths.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            word_ptr  <= '0;
            remaining <= '0;
            word      <= '0;
            beat      <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        word_ptr  <= start_addr[AW-1:2];
                        remaining <= word_count;
                        if (overflow) begin
                            err <= 1'b1;
                        end else if (word_count == '0) begin
                            state <= FINISH;
                        end else begin
                            state <= WAIT_WORD;
                        end
                    end
                end
                WAIT_WORD: begin
                    if (in_valid) begin
                        word  <= in_data;
                        beat  <= '0;
                        we    <= 1'b1;
                        waddr <= {word_ptr, 2'b00};
                        wdata <= in_data[7:0];
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (beat != 2'd3) begin
                        beat  <= beat_next;
                        we    <= 1'b1;
                        waddr <= {word_ptr, beat_next};
                        wdata <= word[{beat_next, 3'b000} +: 8];
                    end else begin
                        word_ptr  <= word_ptr + PTR_ONE;
                        remaining <= remaining - CNT_ONE;
                        if (remaining == CNT_ONE) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            state <= WAIT_WORD;
                        end
                    end
                end
                FINISH: begin
                    done  <= !done;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected byte writes are queued when a
// word is driven and compared as the loader emits them.

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  start_addr;
    logic [8:0]  word_count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        we;
    logic [9:0]  waddr;
    logic [7:0]  wdata;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_seen = 0;
    int          err_seen  = 0;
    int unsigned exp_ptr  = 0;

    imem_loader #(.MEM_BYTES(1024), .AW(10)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (err === 1'b1) err_seen++;
        if (we === 1'b1) begin
            check_eq("ready_low_in_write", 32'(in_ready), 32'd0);
            check_eq("hold_eq_busy", 32'(cpu_hold), 32'(busy));
            if (exp_q.size() == 0) begin
                check_eq("unexpected_we", 32'(we), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_eq("waddr", 32'(waddr), 32'(e.addr));
                check_eq("wdata", 32'(wdata), 32'(e.data));
            end
        end
    end

    function automatic logic [31:0] out_vec();
        return 32'({in_ready, we, waddr, wdata, busy, cpu_hold, done, err});
    endfunction

    // Called at a negedge; returns at the negedge of cycle t+1.
    task automatic do_start(input logic [9:0] a, input logic [8:0] n);
        start      = 1'b1;
        start_addr = a;
        word_count = n;
        exp_ptr    = 32'({a[9:2], 2'b00});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Queues the four expected byte writes, offers the word, and returns at
    // the negedge of the cycle after acceptance (first write beat visible).
    task automatic push_word(input logic [31:0] w, input int idle);
        int guard;
        in_valid = 1'b0;
        repeat (idle) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wr_t e;
            e.addr = 10'(exp_ptr + 32'(i));
            e.data = w[8*i +: 8];
            exp_q.push_back(e);
        end
        exp_ptr += 4;
        in_valid = 1'b1;
        in_data  = w;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("accept_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k;
        k = 0;
        while (done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int e0;
        rst = 1'b1; start = 1'b1; start_addr = 10'h000; word_count = 9'd1;
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF;

        // Reset held two cycles with start/in_valid active.
        @(negedge clk);
        check_eq("rst_outputs_c1", out_vec(), 32'd0);
        @(negedge clk);
        check_eq("rst_outputs_c2", out_vec(), 32'd0);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        check_eq("post_rst_outputs", out_vec(), 32'd0);

        // Single word at 0x000.
        do_start(10'h000, 9'd1);
        check_eq("start_ready_t1", 32'(in_ready), 32'd1);
        check_eq("start_hold_t1", 32'(cpu_hold), 32'd1);
        push_word(32'h0000_0033, 0);
        check_eq("beat0_we", 32'(we), 32'd1);
        repeat (3) @(negedge clk);
        check_eq("beat3_hold", 32'(cpu_hold), 32'd1);
        check_eq("beat3_we", 32'(we), 32'd1);
        @(negedge clk);
        check_eq("single_done_a5", 32'(done), 32'd1);
        check_eq("single_hold_a5", 32'(cpu_hold), 32'd0);
        check_eq("single_we_a5", 32'(we), 32'd0);
        @(negedge clk);
        check_eq("single_done_once", 32'(done), 32'd0);
        check_eq("single_q_empty", 32'(exp_q.size()), 32'd0);

        // Multi-word with stalls, unaligned base.
        d0 = done_seen;
        do_start(10'h012, 9'd3);
        push_word(32'h1122_3344, 3);
        push_word(32'h5566_7788, 3);
        push_word(32'h99AA_BBCC, 3);
        wait_done("multi_done", 20);
        repeat (3) @(negedge clk);
        check_eq("multi_done_count", 32'(done_seen - d0), 32'd1);
        check_eq("multi_q_empty", 32'(exp_q.size()), 32'd0);

        // Range overflow, then exact fit at the top.
        e0 = err_seen;
        do_start(10'h3FC, 9'd2);
        check_eq("ovf_err_t1", 32'(err), 32'd1);
        check_eq("ovf_busy_t1", 32'(busy), 32'd0);
        check_eq("ovf_ready_t1", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_eq("ovf_err_once", 32'(err), 32'd0);
        check_eq("ovf_busy_t2", 32'(busy), 32'd0);
        do_start(10'h004, 9'd256);
        check_eq("ovf256_err", 32'(err), 32'd1);
        @(negedge clk);
        check_eq("ovf_err_count", 32'(err_seen - e0), 32'd2);
        do_start(10'h3FC, 9'd1);
        check_eq("top_fit_ready", 32'(in_ready), 32'd1);
        check_eq("top_fit_noerr", 32'(err), 32'd0);
        push_word(32'hDEAD_BEEF, 0);
        wait_done("top_fit_done", 10);
        @(negedge clk);
        check_eq("top_q_empty", 32'(exp_q.size()), 32'd0);

        // Zero count.
        do_start(10'h040, 9'd0);
        check_eq("zero_done_t1", 32'(done), 32'd0);
        check_eq("zero_ready_t1", 32'(in_ready), 32'd0);
        check_eq("zero_busy_t1", 32'(busy), 32'd0);
        @(negedge clk);
        check_eq("zero_done_t2", 32'(done), 32'd1);
        @(negedge clk);
        check_eq("zero_done_t3", 32'(done), 32'd0);

        // Start while busy is ignored.
        d0 = done_seen;
        do_start(10'h020, 9'd2);
        push_word(32'hCAFE_F00D, 0);
        start = 1'b1; start_addr = 10'h100; word_count = 9'd1;
        @(negedge clk);
        start = 1'b0;
        push_word(32'h0BAD_1DEA, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start_done", 10);
        repeat (2) @(negedge clk);
        check_eq("busy_start_idle", 32'(busy), 32'd0);
        check_eq("busy_start_done_cnt", 32'(done_seen - d0), 32'd1);
        check_eq("busy_start_q_empty", 32'(exp_q.size()), 32'd0);

        // Full-memory load (largest legal count).
        do_start(10'h000, 9'd256);
        check_eq("full_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 256; i++) push_word($urandom, 0);
        wait_done("full_done", 10);
        @(negedge clk);
        check_eq("full_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset during beat 2.
        do_start(10'h080, 9'd2);
        push_word(32'hA1B2_C3D4, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_outputs", out_vec(), 32'd0);
        rst = 1'b0;
        check_eq("midrst_left_cnt", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) check_eq("midrst_left_addr", 32'(exp_q[0].addr), 32'h083);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_eq("midrst_idle", out_vec(), 32'd0);
        do_start(10'h0C0, 9'd1);
        push_word(32'h0102_0304, 0);
        wait_done("fresh_done", 10);
        @(negedge clk);
        check_eq("fresh_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
